// File: rtl/sdu_ram.sv
// sdu_ram: accumulation buffer for the receive path.
// One synchronous write port and one asynchronous read port.
// A same-address read-modify-write completes in a single cycle because the
// read is combinational and the write only lands on the clock edge.
module sdu_ram #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_en
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  // Zero initial contents keep accumulation deterministic in simulation.
  // Reset leaves the contents untouched.
  logic [DWIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  // Write port: reset low suppresses the write whatever wr_en is.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read port: no enable, no register, tracks the array at all times.
  assign rd_data = r_mem[rd_addr];

endmodule

// File: tb/tb_sdu_ram.sv
// Directed self-checking bench for sdu_ram (DWIDTH=32, AWIDTH=16).
module tb_sdu_ram;

  logic        clk;
  logic        reset_n;
  logic [15:0] rd_addr;
  logic [31:0] rd_data;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;

  int unsigned errors;
  int unsigned checks;
  logic [31:0] shadow [16];

  sdu_ram #(.DWIDTH(32), .AWIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] expv);
    checks++;
    assert (rd_data === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, rd_data, expv);
    end
  endtask

  // Write one word with reset released; keep the low-address shadow in step.
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a < 16'd16) shadow[a[3:0]] = d;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] expv);
    rd_addr = a;
    #1;
    check(tag, expv);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    wr_en   = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;

    // Reset state: simulation contents start at zero.
    repeat (3) @(posedge clk);
    #1;
    rd("init_addr0", 16'h0000, 32'h0);
    rd("init_addr100", 16'h0100, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Sequential fill and combinational readback.
    for (int i = 0; i < 16; i++) wr(16'(i), 32'(i));
    for (int i = 0; i < 16; i++) rd($sformatf("fill_%0d", i), 16'(i), 32'(i));

    // Same-address read-modify-write accumulate.
    wr(16'd5, 32'd10);
    @(negedge clk);
    rd_addr = 16'd5;
    wr_addr = 16'd5;
    wr_en   = 1'b1;
    #1;
    check("rmw_0", 32'd10);
    wr_data = rd_data + 32'd7;
    @(posedge clk);
    #1;
    check("rmw_1", 32'd17);
    wr_data = rd_data + 32'd7;
    @(posedge clk);
    #1;
    check("rmw_2", 32'd24);
    wr_data = rd_data + 32'd7;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("rmw_3", 32'd31);
    shadow[5] = 32'd31;

    // Reset blocks writes and retains contents.
    wr(16'd3, 32'hA5A5_A5A5);
    @(negedge clk);
    reset_n = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 16'd3;
    wr_data = 32'h0;
    rd_addr = 16'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_track", 32'hA5A5_A5A5);
    @(negedge clk);
    wr_en   = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rst_keep", 32'hA5A5_A5A5);
    wr(16'd3, 32'h0);
    rd("rst_after", 16'd3, 32'h0);

    // Top and bottom addresses, no aliasing.
    wr(16'hFFFF, 32'hDEAD_BEEF);
    wr(16'h0000, 32'h1234_5678);
    rd("wrap_ffff", 16'hFFFF, 32'hDEAD_BEEF);
    rd("wrap_0000", 16'h0000, 32'h1234_5678);
    rd("wrap_fffe", 16'hFFFE, 32'h0);
    rd("wrap_0001", 16'h0001, 32'h1);

    // Independent ports: write 7 while reading 9.
    @(negedge clk);
    rd_addr = 16'd9;
    wr_addr = 16'd7;
    wr_data = 32'h0000_0077;
    wr_en   = 1'b1;
    #1;
    check("indep_pre", 32'd9);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check("indep_post", 32'd9);
    shadow[7] = 32'h0000_0077;
    rd("indep_w7", 16'd7, 32'h0000_0077);

    // wr_en low: stray address/data activity must not alter contents.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_addr = 16'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_en   = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) rd($sformatf("hold_%0d", i), 16'(i), shadow[i]);
    rd("hold_ffff", 16'hFFFF, 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
